muldiv_unit: RTL and testbench

Iterative multiply/divide unit sitting beside the ALU in the execute stage. It consumes the same register operands the ALU consumes (rs/rt as A/B) and produces the architectural HI/LO pair for MULT/MULTU/DIV/DIVU, with MTHI/MTLO write ports. Downstream, HI/LO feed MFHI/MFLO through the writeback mux. The hazard unit uses busy/done to stall dependent instructions.

---
 rtl/muldiv_unit_pkg.sv | 31 +++
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Types and constants shared by the multiply/divide unit and its bus.
// Provides word_t, the operation and FSM enums, and the iteration count.
package muldiv_unit_pkg;

    typedef logic [31:0] word_t;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldivop_t;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        FIX
    } muldiv_state_t;

    function automatic logic md_is_div(muldivop_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(muldivop_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage bus to the multiply/divide unit.
// master: start/op/A/B and MTHI/MTLO writes; slave: busy/done/div_by_zero/hi/lo.
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic      start;
    muldivop_t op;
    word_t     A;
    word_t     B;
    logic      hi_wen;
    logic      lo_wen;
    word_t     wdata;
    logic      busy;
    logic      done;
    logic      div_by_zero;
    word_t     hi;
    word_t     lo;

    modport master (
        output start, op, A, B, hi_wen, lo_wen, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, A, B, hi_wen, lo_wen, wdata,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit producing the HI/LO pair.
// Ports: CLK, nRST (sync, active-low), bus (muldiv_unit_if.slave).
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int ITER = MULDIV_ITER
) (
    input  logic          CLK,
    input  logic          nRST,
    muldiv_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    if (ITER != 32) begin : g_iter_chk
        $error("muldiv_unit: ITER must equal 32");
    end

    muldiv_state_t    state, state_n;
    logic [CNT_W-1:0] cnt;
    muldivop_t        op_q;
    word_t            acc_q;
    word_t            low_q;
    word_t            opnd_q;
    logic             neg_q;
    logic             rneg_q;
    word_t            hi_q;
    word_t            lo_q;
    logic             done_q;
    logic             dbz_q;
    logic             done_d;
    logic             dbz_d;

    logic  div_op;
    logic  a_neg;
    logic  b_neg;
    logic  b_zero;

    assign div_op = md_is_div(op_q);
    assign a_neg  = md_is_signed(op_q) & low_q[31];
    assign b_neg  = md_is_signed(op_q) & opnd_q[31];
    assign b_zero = (opnd_q == '0);

    // One shared 33-bit adder: add step for multiply,
    // trial subtract of the shifted partial remainder for divide.
    logic [32:0] add_a;
    logic [32:0] add_b;
    logic [32:0] add_s;
    logic [32:0] mul_sum;

    assign add_a   = div_op ? {acc_q, low_q[31]} : {1'b0, acc_q};
    assign add_b   = {1'b0, opnd_q} ^ {33{div_op}};
    assign add_s   = add_a + add_b + {32'b0, div_op};
    assign mul_sum = low_q[0] ? add_s : {1'b0, acc_q};

    logic [63:0] prod;
    logic [63:0] prod_f;
    word_t       quo_f;
    word_t       rem_f;

    assign prod   = {acc_q, low_q};
    assign prod_f = neg_q ? -prod : prod;
    assign quo_f  = neg_q ? -low_q : low_q;
    assign rem_f  = rneg_q ? -acc_q : acc_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = PREP;
                end
            end
            PREP: begin
                if (div_op && b_zero) begin
                    state_n = IDLE;
                    done_d  = 1'b1;
                    dbz_d   = 1'b1;
                end else begin
                    state_n = CALC;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                state_n = IDLE;
                done_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt    <= '0;
            op_q   <= MD_MULT;
            acc_q  <= '0;
            low_q  <= '0;
            opnd_q <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            dbz_q  <= dbz_d;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        low_q  <= bus.A;
                        opnd_q <= bus.B;
                    end
                    if (bus.hi_wen) begin
                        hi_q <= bus.wdata;
                    end
                    if (bus.lo_wen) begin
                        lo_q <= bus.wdata;
                    end
                end
                PREP: begin
                    if (div_op && b_zero) begin
                        hi_q <= low_q;
                        lo_q <= '1;
                    end else begin
                        low_q  <= a_neg ? -low_q : low_q;
                        opnd_q <= b_neg ? -opnd_q : opnd_q;
                        acc_q  <= '0;
                        cnt    <= '0;
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (div_op) begin
                        // add_s[32] set means the trial subtract borrowed.
                        if (!add_s[32]) begin
                            acc_q <= add_s[31:0];
                            low_q <= {low_q[30:0], 1'b1};
                        end else begin
                            acc_q <= add_a[31:0];
                            low_q <= {low_q[30:0], 1'b0};
                        end
                    end else begin
                        acc_q <= mul_sum[32:1];
                        low_q <= {mul_sum[0], low_q[31:1]};
                    end
                end
                FIX: begin
                    if (div_op) begin
                        hi_q <= rem_f;
                        lo_q <= quo_f;
                    end else begin
                        hi_q <= prod_f[63:32];
                        lo_q <= prod_f[31:0];
                    end
                end
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, random ops
// against an arithmetic model, and busy/reset/MTHI-MTLO sequences.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk;
    logic nrst;
    int   tests;
    int   fails;

    muldiv_unit_if md ();

    muldiv_unit dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        muldivop_t op;
        word_t     a;
        word_t     b;
        word_t     hi;
        word_t     lo;
        logic      dbz;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input muldivop_t op, input word_t a,
                                  input word_t b, output word_t h,
                                  output word_t l, output logic z);
        logic signed [63:0] p;
        z = 1'b0;
        h = '0;
        l = '0;
        if (op == MD_MULT) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            h = p[63:32];
            l = p[31:0];
        end else if (op == MD_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            h = a;
            l = 32'hFFFFFFFF;
            z = 1'b1;
        end else if (op == MD_DIV) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                l = 32'h80000000;
                h = 32'd0;
            end else begin
                l = $signed(a) / $signed(b);
                h = $signed(a) % $signed(b);
            end
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction

    // Starts at the current (idle) cycle; returns in the done cycle.
    task automatic run_op(input muldivop_t op, input word_t a,
                          input word_t b, input int inject,
                          output word_t rh, output word_t rl,
                          output logic rdbz, output int dcyc,
                          output int bcnt);
        md.start = 1'b1;
        md.op    = op;
        md.A     = a;
        md.B     = b;
        tick();
        md.start = 1'b0;
        md.A     = $urandom;
        md.B     = $urandom;
        dcyc = 0;
        bcnt = 0;
        rh   = '0;
        rl   = '0;
        rdbz = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (md.busy) bcnt++;
            if (md.done) begin
                dcyc = c;
                rh   = md.hi;
                rl   = md.lo;
                rdbz = md.div_by_zero;
                break;
            end
            if (c == inject) begin
                md.start  = 1'b1;
                md.op     = MD_DIVU;
                md.hi_wen = 1'b1;
                md.wdata  = 32'h1234;
            end
            tick();
            md.start  = 1'b0;
            md.hi_wen = 1'b0;
        end
    endtask

    task automatic check_op(string tag, muldivop_t op, word_t a,
                            word_t b, int inject);
        word_t rh, rl, eh, el;
        logic  rz, ez;
        int    dc, bc;
        model(op, a, b, eh, el, ez);
        run_op(op, a, b, inject, rh, rl, rz, dc, bc);
        chk({tag, " done_cycle"}, 64'(dc), ez ? 64'd2 : 64'd35);
        chk({tag, " busy_cycles"}, 64'(bc), ez ? 64'd1 : 64'd34);
        chk({tag, " hi"}, 64'(rh), 64'(eh));
        chk({tag, " lo"}, 64'(rl), 64'(el));
        chk({tag, " dbz"}, 64'(rz), 64'(ez));
    endtask

    initial begin
        word_t rh, rl;
        logic  rz;
        int    dc, bc;
        tests = 0;
        fails = 0;

        vecs[0] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1] = '{MD_MULT, 32'hFFFFFFFD, 32'h00000007,
                    32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2] = '{MD_DIVU, 32'd100, 32'd7,
                    32'h00000002, 32'h0000000E, 1'b0};
        vecs[3] = '{MD_DIV, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4] = '{MD_DIVU, 32'd5, 32'd0,
                    32'h00000005, 32'hFFFFFFFF, 1'b1};
        vecs[5] = '{MD_MULTU, 32'd3, 32'd4,
                    32'h00000000, 32'h0000000C, 1'b0};
        vecs[6] = '{MD_DIV, 32'h80000000, 32'hFFFFFFFF,
                    32'h00000000, 32'h80000000, 1'b0};
        vecs[7] = '{MD_MULT, 32'h80000000, 32'h80000000,
                    32'h40000000, 32'h00000000, 1'b0};

        md.start  = 1'b0;
        md.op     = MD_MULT;
        md.A      = '0;
        md.B      = '0;
        md.hi_wen = 1'b0;
        md.lo_wen = 1'b0;
        md.wdata  = '0;
        nrst      = 1'b0;
        tick();
        tick();
        nrst = 1'b1;

        chk("reset hi", 64'(md.hi), 64'd0);
        chk("reset lo", 64'(md.lo), 64'd0);
        chk("reset busy", 64'(md.busy), 64'd0);
        chk("reset done", 64'(md.done), 64'd0);
        chk("reset dbz", 64'(md.div_by_zero), 64'd0);

        // vecs[4] is div-by-zero; vecs[5] starts in its done cycle.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0,
                   rh, rl, rz, dc, bc);
            chk($sformatf("vec%0d done_cycle", i), 64'(dc),
                vecs[i].dbz ? 64'd2 : 64'd35);
            chk($sformatf("vec%0d busy_cycles", i), 64'(bc),
                vecs[i].dbz ? 64'd1 : 64'd34);
            chk($sformatf("vec%0d hi", i), 64'(rh), 64'(vecs[i].hi));
            chk($sformatf("vec%0d lo", i), 64'(rl), 64'(vecs[i].lo));
            chk($sformatf("vec%0d dbz", i), 64'(rz), 64'(vecs[i].dbz));
        end

        // start + MTHI while busy are both ignored.
        check_op("busy_ignore", MD_MULT, 32'h00012345, 32'hFFFFFF77, 10);
        tick();
        chk("busy_ignore no_restart", 64'(md.busy), 64'd0);
        chk("busy_ignore done_clear", 64'(md.done), 64'd0);

        // MTHI in the same idle cycle as start is later overwritten.
        md.hi_wen = 1'b1;
        md.wdata  = 32'h5555AAAA;
        check_op("mthi_start", MD_MULTU, 32'd6, 32'd7, 0);
        md.hi_wen = 1'b0;

        // Plain MTHI in idle.
        md.hi_wen = 1'b1;
        md.wdata  = 32'hCAFEF00D;
        tick();
        md.hi_wen = 1'b0;
        chk("mthi idle", 64'(md.hi), 64'hCAFEF00D);

        for (int i = 0; i < 40; i++) begin
            muldivop_t op;
            word_t     a, b;
            op = muldivop_t'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) begin
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end
            check_op($sformatf("rand%0d", i), op, a, b, 0);
        end

        // Reset in the middle of a divide.
        md.start = 1'b1;
        md.op    = MD_DIVU;
        md.A     = 32'd100;
        md.B     = 32'd7;
        tick();
        md.start = 1'b0;
        repeat (19) tick();
        chk("mid_reset busy_before", 64'(md.busy), 64'd1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        chk("mid_reset busy", 64'(md.busy), 64'd0);
        chk("mid_reset hi", 64'(md.hi), 64'd0);
        chk("mid_reset lo", 64'(md.lo), 64'd0);
        chk("mid_reset done", 64'(md.done), 64'd0);
        md.lo_wen = 1'b1;
        md.wdata  = 32'h0000ABCD;
        tick();
        md.lo_wen = 1'b0;
        chk("mtlo lo", 64'(md.lo), 64'h0000ABCD);
        chk("mtlo hi", 64'(md.hi), 64'd0);
        bc = 0;
        for (int c = 0; c < 20; c++) begin
            if (md.done || md.busy) bc++;
            tick();
        end
        chk("mid_reset no_late_done", 64'(bc), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
